// File: rtl/mem_access_unit_if.sv
// Request/response handshake from the EX/MEM pipeline stage plus the DataMemory port.
// The slave modport is the memory access unit; the master modport is the pipeline/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_address, mem_read, mem_write,
           mem_data_in, busy
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_address, mem_read, mem_write,
           mem_data_in, busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and a byte-addressed DataMemory.
// Sub-doubleword stores are done as read-modify-write of the full 8-byte word.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] old_q, old_d;
  logic [63:0] rdata_q, rdata_d;
  logic        req_err;
  logic [63:0] mask;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'd0:    return {{56{sgn & data[7]}},  data[7:0]};
      2'd1:    return {{48{sgn & data[15]}}, data[15:0]};
      2'd2:    return {{32{sgn & data[31]}}, data[31:0]};
      default: return data;
    endcase
  endfunction

  always_comb begin
    case (bus.req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = bus.req_addr[0];
      2'd2:    req_err = |bus.req_addr[1:0];
      default: req_err = |bus.req_addr[2:0];
    endcase
    if (bus.req_addr > LAST_ADDR) req_err = 1'b1;
  end

  assign mask            = size_mask(size_q);
  assign bus.resp_rdata  = rdata_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    signed_d         = signed_q;
    err_d            = err_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    old_d            = old_q;
    rdata_d          = rdata_q;
    bus.req_ready    = 1'b0;
    bus.busy         = 1'b1;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_address  = '0;
    bus.mem_data_in  = '0;
    bus.resp_valid   = 1'b0;
    bus.resp_err     = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          err_d    = req_err;
          if (req_err)                                 state_d = RESP;
          else if (bus.req_write && bus.req_size == 2'd3) state_d = WR;
          else                                         state_d = RD;
        end
      end
      RD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = addr_q;
        if (write_q) begin
          old_d   = bus.mem_data_out;
          state_d = WR;
        end else begin
          rdata_d = extend(bus.mem_data_out, size_q, signed_q);
          state_d = RESP;
        end
      end
      WR: begin
        // Mask is all ones for doublewords, so the stale old_q is never used there.
        bus.mem_write   = 1'b1;
        bus.mem_address = addr_q;
        bus.mem_data_in = (wdata_q & mask) | (old_q & ~mask);
        state_d         = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_write decodes straight from state_q, so an async reset kills it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
